// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, frame
// classes and the row/column to hex key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_class_e;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  localparam logic [3:0] COL_RESET = 4'hE;

  // Indexed by row*4 + column; element 0 is the least significant nibble.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,
    4'hC, 4'h9,     4'h8, 4'h7,
    4'hB, 4'h6,     4'h5, 4'h4,
    4'hA, 4'h3,     4'h2, 4'h1
  };

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[idx];
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; resets to
// all-ones so no key appears pressed while reset is asserted.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_async,
  output logic [3:0] rows_sync
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = rows_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rows_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce and valid/ack output.
// Define KEYPAD_DIGIT_ENTRY_EN to add the four-digit BCD entry register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Columns,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  input  logic       KeyAck,
  output logic       Overrun
`ifdef KEYPAD_DIGIT_ENTRY_EN
  ,
  output logic [3:0] BCD3,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0
`endif
);

  localparam logic [SCAN_DIV_W-1:0] DIV_ONE = 1;
  localparam logic [3:0]            DS_CNT  = 4'(DEBOUNCE_SCANS);

  logic [3:0] rows_sync;
  logic [3:0] row_hit;

  keypad_row_sync u_row_sync (
    .clk        (Clk),
    .rst_n      (Reset),
    .rows_async (Rows),
    .rows_sync  (rows_sync)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_row_hit
    assign row_hit[gi] = ~rows_sync[gi];
  end

  // Scan timing: divider, column strobe and column index
  logic [SCAN_DIV_W-1:0] div_q, div_d;
  logic [3:0]            col_q, col_d;
  logic [1:0]            col_idx_q, col_idx_d;
  logic                  tick;
  logic                  frame_end;

  always_comb begin
    tick      = &div_q;
    frame_end = tick && (col_idx_q == 2'd3);
    div_d     = div_q + DIV_ONE;
    col_d     = col_q;
    col_idx_d = col_idx_q;
    if (tick) begin
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  // Frame accumulator: seen_q counts low bits (saturating at 2 = many)
  logic [1:0]   seen_q, seen_d;
  logic [3:0]   idx_q, idx_d;
  logic [1:0]   seen_v;
  logic [3:0]   idx_v;
  frame_class_e frame_class;
  logic [3:0]   frame_idx;

  always_comb begin
    seen_d      = seen_q;
    idx_d       = idx_q;
    seen_v      = seen_q;
    idx_v       = idx_q;
    frame_class = FR_NONE;
    frame_idx   = idx_q;
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        if (row_hit[r]) begin
          if (seen_v == 2'd0) begin
            idx_v  = {2'(r), col_idx_q};
            seen_v = 2'd1;
          end else begin
            seen_v = 2'd2;
          end
        end
      end
      if (frame_end) begin
        case (seen_v)
          2'd0:    frame_class = FR_NONE;
          2'd1:    frame_class = FR_SINGLE;
          default: frame_class = FR_MULTI;
        endcase
        frame_idx = idx_v;
        seen_d    = 2'd0;
        idx_d     = 4'd0;
      end else begin
        seen_d = seen_v;
        idx_d  = idx_v;
      end
    end
  end

  // Debounce FSM, advanced only at frame ends
  kp_state_e  state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       emit;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 4'd1;
    emit    = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_class == FR_SINGLE) begin
            state_d = ST_DEBOUNCE;
            cand_d  = frame_idx;
            cnt_d   = 4'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_class == FR_SINGLE && frame_idx == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_CNT) begin
              emit    = 1'b1;
              state_d = ST_PRESSED;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (frame_class == FR_NONE) begin
            state_d = ST_RELEASE;
            cnt_d   = 4'd1;
          end
        end
        ST_RELEASE: begin
          if (frame_class == FR_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_CNT) begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output handshake; an ack coinciding with an emit hands over the new key
  logic [3:0] emit_code;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    emit_code = key_code(cand_q);
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (emit) begin
      if (!valid_q || KeyAck) begin
        code_d  = emit_code;
        valid_d = 1'b1;
        if (KeyAck) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (KeyAck && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q     <= '0;
      col_q     <= COL_RESET;
      col_idx_q <= 2'd0;
      seen_q    <= 2'd0;
      idx_q     <= 4'd0;
      state_q   <= ST_IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      seen_q    <= seen_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign Columns  = col_q;
  assign KeyCode  = code_q;
  assign KeyValid = valid_q;
  assign Overrun  = overrun_q;

`ifdef KEYPAD_DIGIT_ENTRY_EN
  // Digit register follows every emit, including those that overrun
  logic [3:0][3:0] digits_q, digits_d;

  always_comb begin
    digits_d = digits_q;
    if (emit) begin
      if (emit_code <= 4'd9) begin
        digits_d = {digits_q[2:0], emit_code};
      end else if (emit_code == KEY_STAR) begin
        digits_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign BCD3 = digits_q[3];
  assign BCD2 = digits_q[2];
  assign BCD1 = digits_q[1];
  assign BCD0 = digits_q[0];
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives Rows
// from the strobed Columns; a frame-level reference model predicts outputs.
module tb_keypad_scanner;

  localparam int DS    = 3;
  localparam int FRAME = 64;

  logic       Clk    = 1'b0;
  logic       Reset  = 1'b1;
  logic       KeyAck = 1'b0;
  logic [3:0] Rows;
  logic [3:0] Columns;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       Overrun;
`ifdef KEYPAD_DIGIT_ENTRY_EN
  logic [3:0] BCD3, BCD2, BCD1, BCD0;
`endif

  logic [15:0] pressed = '0;
  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int         m_div, m_col, m_seen, m_idx, m_run, m_key, m_rel, m_emits;
  int         lag_err, dut_rises;
  bit         m_armed, m_valid, m_ovr, prev_valid;
  logic [3:0] m_code;
  logic [3:0] m_bcd [4];
  logic [15:0] ph1, ph2;
  logic [3:0] m_map [16];
  logic [3:0] col_seq [4];

  always #5 Clk = ~Clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      Rows[r] = ~|(pressed[r*4 +: 4] & ~Columns);
    end
  end

  keypad_scanner #(
    .SCAN_DIV_W     (4),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Rows     (Rows),
    .Columns  (Columns),
    .KeyCode  (KeyCode),
    .KeyValid (KeyValid),
    .KeyAck   (KeyAck),
    .Overrun  (Overrun)
`ifdef KEYPAD_DIGIT_ENTRY_EN
    ,
    .BCD3     (BCD3),
    .BCD2     (BCD2),
    .BCD1     (BCD1),
    .BCD0     (BCD0)
`endif
  );

  task automatic model_reset();
    m_div = 0; m_col = 0; m_seen = 0; m_idx = 0;
    m_run = 0; m_key = 0; m_rel = 0; m_armed = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0; prev_valid = 1'b0;
    ph1 = '0; ph2 = '0;
    for (int i = 0; i < 4; i++) m_bcd[i] = 4'h0;
  endtask

  // A key is accepted after DS identical single-key frames while armed; the
  // scanner re-arms after DS consecutive empty frames.
  task automatic model_frame(output bit emit);
    emit = 1'b0;
    if (m_armed) begin
      if (m_seen == 1) begin
        if (m_run == 0) begin
          m_key = m_idx;
          m_run = 1;
        end else if (m_idx == m_key) begin
          m_run++;
        end else begin
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == DS) begin
        emit = 1'b1; m_armed = 1'b0; m_rel = 0;
      end
    end else begin
      if (m_seen == 0) m_rel++;
      else m_rel = 0;
      if (m_rel == DS) begin
        m_armed = 1'b1; m_run = 0;
      end
    end
  endtask

  task automatic step();
    bit         emit;
    logic [3:0] c;
    logic [3:0] exp_cols;
    emit = 1'b0;
    @(posedge Clk);
    if (m_div == 15) begin
      for (int r = 0; r < 4; r++) begin
        if (ph2[r*4 + m_col]) begin
          if (m_seen == 0) m_idx = r*4 + m_col;
          m_seen++;
        end
      end
      if (m_col == 3) begin
        model_frame(emit);
        m_seen = 0;
      end
      m_col = (m_col + 1) % 4;
    end
    m_div = (m_div + 1) % 16;
    ph2 = ph1;
    ph1 = pressed;
    if (emit) begin
      m_emits++;
      c = m_map[m_key];
      if (!m_valid || KeyAck) begin
        m_code = c; m_valid = 1'b1;
        if (KeyAck) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
      if (c <= 4'd9) begin
        m_bcd[3] = m_bcd[2]; m_bcd[2] = m_bcd[1]; m_bcd[1] = m_bcd[0]; m_bcd[0] = c;
      end else if (c == 4'hE) begin
        for (int i = 0; i < 4; i++) m_bcd[i] = 4'h0;
      end
    end else if (KeyAck && m_valid) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
    @(negedge Clk);
    exp_cols = 4'hF ^ (4'h1 << m_col);
    if ({KeyValid, KeyCode, Overrun, Columns} !== {m_valid, m_code, m_ovr, exp_cols}) lag_err++;
`ifdef KEYPAD_DIGIT_ENTRY_EN
    if ({BCD3, BCD2, BCD1, BCD0} !== {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]}) lag_err++;
`endif
    if (KeyValid && !prev_valid) begin
      dut_rises++;
      $display("key accepted: code=%h overrun=%0b t=%0t", KeyCode, Overrun, $time);
    end
    prev_valid = KeyValid;
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic press(input int idx, input int frames);
    pressed = 16'h0001 << idx;
    hold(frames * FRAME);
  endtask

  task automatic release_keys(input int frames);
    pressed = '0;
    hold(frames * FRAME);
  endtask

  task automatic ack_pulse();
    KeyAck = 1'b1;
    step();
    KeyAck = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (Columns !== 4'hE) begin n_err++; $display("FAIL reset_columns: got %h want e", Columns); end
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", KeyValid); end
    n_checks++; if (KeyCode !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h want 0", KeyCode); end
    n_checks++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", Overrun); end
    repeat (3) @(negedge Clk);
    model_reset();
    Reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      exp = col_seq[((k + 1) / 16) % 4];
      n_checks++;
      if (Columns !== exp) begin
        n_err++;
        $display("FAIL column_rotation: cycle %0d got %h want %h", k + 1, Columns, exp);
      end
    end
    hold(1000 - 64);
    n_checks++; if (dut_rises !== 0) begin n_err++; $display("FAIL idle_no_emit: got %0d emits want 0", dut_rises); end
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", KeyValid); end
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL idle_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

  task automatic test_single_key();
    int r0;
    hold($urandom_range(0, 63));
    r0 = dut_rises;
    press(6, 5);
    n_checks++; if (KeyValid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", KeyValid); end
    n_checks++; if (KeyCode !== 4'h6) begin n_err++; $display("FAIL single_code: got %h want 6", KeyCode); end
    n_checks++; if (dut_rises - r0 !== 1) begin n_err++; $display("FAIL single_count: got %0d emits want 1", dut_rises - r0); end
    ack_pulse();
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL single_ack: valid got %b want 0", KeyValid); end
    release_keys(DS + 1);
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL single_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

  task automatic test_bouncy();
    int r0;
    r0 = dut_rises;
    for (int h = 0; h < 7; h++) begin
      pressed = (h % 2 == 0) ? (16'h0001 << 10) : 16'h0000;
      hold(20);
    end
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL bounce_early: valid got %b want 0", KeyValid); end
    hold(4 * FRAME);
    n_checks++; if (dut_rises - r0 !== 1) begin n_err++; $display("FAIL bounce_count: got %0d emits want 1", dut_rises - r0); end
    n_checks++; if (KeyCode !== 4'h9) begin n_err++; $display("FAIL bounce_code: got %h want 9", KeyCode); end
    ack_pulse();
    release_keys(DS + 1);
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL bounce_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

  task automatic test_multi();
    int r0;
    r0 = dut_rises;
    pressed = 16'h0003;
    hold(10 * FRAME);
    n_checks++; if (dut_rises - r0 !== 0) begin n_err++; $display("FAIL multi_count: got %0d emits want 0", dut_rises - r0); end
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL multi_valid: got %b want 0", KeyValid); end
    release_keys(DS + 1);
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL multi_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

  task automatic test_overrun();
    int guard;
    press(5, 5);
    release_keys(DS + 1);
    press(8, 5);
    n_checks++; if (KeyCode !== 4'h5) begin n_err++; $display("FAIL ovr_code: got %h want 5", KeyCode); end
    n_checks++; if (Overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", Overrun); end
    n_checks++; if (KeyValid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", KeyValid); end
    ack_pulse();
    n_checks++; if ({KeyValid, Overrun} !== 2'b00) begin n_err++; $display("FAIL ovr_ack: valid,ovr got %b want 00", {KeyValid, Overrun}); end
    release_keys(DS + 1);
    press(10, 5);
    release_keys(DS + 1);
    press(9, 5);
    release_keys(DS + 1);
    n_checks++; if ({KeyCode, Overrun} !== {4'h9, 1'b1}) begin n_err++; $display("FAIL ovr_second: code,ovr got %h,%b want 9,1", KeyCode, Overrun); end
    pressed = 16'h0001;
    guard = 0;
    while (!(m_armed && m_run == DS - 1) && guard < 400) begin step(); guard++; end
    while (!(m_div == 15 && m_col == 3) && guard < 400) begin step(); guard++; end
    n_checks++; if (guard >= 400) begin n_err++; $display("FAIL coincide_wait: timed out after %0d cycles want < 400", guard); end
    ack_pulse();
    n_checks++; if (KeyValid !== 1'b1) begin n_err++; $display("FAIL coincide_valid: got %b want 1", KeyValid); end
    n_checks++; if (KeyCode !== 4'h1) begin n_err++; $display("FAIL coincide_code: got %h want 1", KeyCode); end
    n_checks++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL coincide_overrun: got %b want 0", Overrun); end
    ack_pulse();
    release_keys(DS + 1);
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL ovr_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

  task automatic test_reset_mid_debounce();
    int guard;
    int r0;
    pressed = 16'h0004;
    guard = 0;
    while (!(m_armed && m_run == 2) && guard < 400) begin step(); guard++; end
    n_checks++; if (guard >= 400) begin n_err++; $display("FAIL midreset_wait: timed out after %0d cycles want < 400", guard); end
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (Columns !== 4'hE) begin n_err++; $display("FAIL midreset_columns: got %h want e", Columns); end
    n_checks++; if (KeyValid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", KeyValid); end
    repeat (2) @(negedge Clk);
    model_reset();
    Reset = 1'b1;
    r0 = dut_rises;
    hold(2 * FRAME);
    n_checks++; if (dut_rises - r0 !== 0) begin n_err++; $display("FAIL midreset_discard: got %0d emits want 0", dut_rises - r0); end
    hold(3 * FRAME);
    n_checks++; if ({KeyValid, KeyCode} !== {1'b1, 4'h3}) begin n_err++; $display("FAIL midreset_fresh: valid,code got %b,%h want 1,3", KeyValid, KeyCode); end
    ack_pulse();
    release_keys(DS + 1);
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL midreset_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask

`ifdef KEYPAD_DIGIT_ENTRY_EN
  task automatic test_digits();
    int seq_idx [5];
    seq_idx = '{0, 1, 2, 4, 5};
    for (int i = 0; i < 5; i++) begin
      press(seq_idx[i], 5);
      ack_pulse();
      release_keys(DS + 1);
    end
    n_checks++; if ({BCD3, BCD2, BCD1, BCD0} !== 16'h2345) begin n_err++; $display("FAIL digits_shift: got %h want 2345", {BCD3, BCD2, BCD1, BCD0}); end
    press(12, 5); ack_pulse(); release_keys(DS + 1);
    n_checks++; if ({BCD3, BCD2, BCD1, BCD0} !== 16'h0000) begin n_err++; $display("FAIL digits_clear: got %h want 0000", {BCD3, BCD2, BCD1, BCD0}); end
    press(8, 5); ack_pulse(); release_keys(DS + 1);
    press(3, 5); ack_pulse(); release_keys(DS + 1);
    n_checks++; if ({BCD3, BCD2, BCD1, BCD0} !== 16'h0007) begin n_err++; $display("FAIL digits_letter: got %h want 0007", {BCD3, BCD2, BCD1, BCD0}); end
    n_checks++; if (lag_err !== 0) begin n_err++; $display("FAIL digits_tracking: %0d cycles off model want 0", lag_err); end
    lag_err = 0;
  endtask
`endif

  task automatic test_random();
    int sel, k1, k2, len, e0;
    e0 = m_emits;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      k1  = $urandom_range(0, 15);
      k2  = (k1 + $urandom_range(1, 15)) % 16;
      if (sel < 6)      pressed = 16'h0001 << k1;
      else if (sel < 8) pressed = 16'h0000;
      else              pressed = (16'h0001 << k1) | (16'h0001 << k2);
      len = $urandom_range(30, 400);
      for (int c = 0; c < len; c++) begin
        KeyAck = ($urandom_range(0, 15) == 0);
        step();
      end
      KeyAck = 1'b0;
      n_checks++;
      if (lag_err !== 0) begin
        n_err++;
        $display("FAIL random_iter%0d: %0d cycles off model want 0 (valid=%b code=%h ovr=%b)", it, lag_err, KeyValid, KeyCode, Overrun);
      end
      lag_err = 0;
    end
    n_checks++; if (m_emits == e0 && dut_rises == 0) begin n_err++; $display("FAIL random_activity: no emits observed want some"); end
  endtask

  initial begin
    m_map   = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    col_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
    m_emits = 0; lag_err = 0; dut_rises = 0;
    model_reset();
    test_reset();
    test_single_key();
    test_bouncy();
    test_multi();
    test_overrun();
    test_reset_mid_debounce();
`ifdef KEYPAD_DIGIT_ENTRY_EN
    test_digits();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
